// File: rtl/maindec_mc.sv
`default_nettype none
// ============================================================================
// Module      : maindec_mc
// Description : Multicycle main control FSM for the 16-bit CPU. Sequences
//               fetch/decode/execute/memory/writeback with mem_ready stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module maindec_mc #(
    parameter int            OP_W     = 3,
    parameter logic [OP_W-1:0] OP_RTYPE = OP_W'(0),
    parameter logic [OP_W-1:0] OP_LW    = OP_W'(1),
    parameter logic [OP_W-1:0] OP_SW    = OP_W'(2),
    parameter logic [OP_W-1:0] OP_BEQ   = OP_W'(3),
    parameter logic [OP_W-1:0] OP_ADDI  = OP_W'(4),
    parameter logic [OP_W-1:0] OP_J     = OP_W'(5)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            iord,
    output logic            irwrite,
    output logic            pcwrite,
    output logic            branch,
    output logic [1:0]      pcsrc,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      aluop,
    output logic            regdst,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            memwrite,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    logic       w_iord, w_irwrite, w_pcwrite, w_branch, w_alusrca;
    logic       w_regdst, w_memtoreg, w_regwrite, w_memwrite;
    logic       w_instr_done, w_illegal_op;
    logic [1:0] w_pcsrc, w_alusrcb, w_aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_iord       = 1'b0;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_pcsrc      = 2'b00;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_aluop      = 2'b00;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_memwrite   = 1'b0;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                if (op == OP_RTYPE)                  w_next = S_EXEC;
                else if (op == OP_LW || op == OP_SW) w_next = S_MEMADR;
                else if (op == OP_BEQ)               w_next = S_BRANCH;
                else if (op == OP_ADDI)              w_next = S_ADDIEX;
                else if (op == OP_J)                 w_next = S_JUMP;
                else begin
                    w_next       = S_FETCH;
                    w_illegal_op = 1'b1;
                end
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memtoreg   = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                // Write is held until memory accepts it; completion pulses on that cycle.
                w_iord       = 1'b1;
                w_memwrite   = 1'b1;
                w_instr_done = mem_ready;
                w_next       = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst     = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca    = 1'b1;
                w_aluop      = 2'b01;
                w_pcsrc      = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pcsrc      = 2'b10;
                w_pcwrite    = 1'b1;
                w_instr_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks every control immediately so an aborted access cannot write.
    assign iord       = w_iord       & ~reset;
    assign irwrite    = w_irwrite    & ~reset;
    assign pcwrite    = w_pcwrite    & ~reset;
    assign branch     = w_branch     & ~reset;
    assign pcsrc      = w_pcsrc      & {2{~reset}};
    assign alusrca    = w_alusrca    & ~reset;
    assign alusrcb    = w_alusrcb    & {2{~reset}};
    assign aluop      = w_aluop      & {2{~reset}};
    assign regdst     = w_regdst     & ~reset;
    assign memtoreg   = w_memtoreg   & ~reset;
    assign regwrite   = w_regwrite   & ~reset;
    assign memwrite   = w_memwrite   & ~reset;
    assign instr_done = w_instr_done & ~reset;
    assign illegal_op = w_illegal_op & ~reset;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_maindec_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_maindec_mc
// Description : Directed bench for maindec_mc with a per-cycle expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maindec_mc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] op = 3'd0;
    logic       mem_ready = 1'b1;
    logic       iord, irwrite, pcwrite, branch, alusrca;
    logic       regdst, memtoreg, regwrite, memwrite, instr_done, illegal_op;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic [3:0] state;

    typedef struct packed {
        logic       iord, irwrite, pcwrite, branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb, aluop;
        logic       regdst, memtoreg, regwrite, memwrite, instr_done, illegal_op;
    } outs_t;

    typedef struct {
        string      tag;
        logic [3:0] st;
        outs_t      o;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    maindec_mc dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .memwrite(memwrite), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // Expected control word for a state, written from the control table.
    function automatic outs_t model(input logic [3:0] s, input logic mr,
                                    input logic [2:0] o, input logic rst);
        outs_t e;
        e = '0;
        if (!rst) begin
            case (s)
                4'd0:  begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
                4'd1:  begin e.alusrcb = 2'b11; e.illegal_op = (o > 3'd5); end
                4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                4'd3:  e.iord = 1'b1;
                4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1; end
                4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; e.instr_done = mr; end
                4'd6:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
                4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1; end
                4'd8:  begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01;
                             e.branch = 1'b1; e.instr_done = 1'b1; end
                4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                4'd10: begin e.regwrite = 1'b1; e.instr_done = 1'b1; end
                4'd11: begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.instr_done = 1'b1; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    function automatic outs_t observed();
        outs_t a;
        a = {iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb, aluop,
             regdst, memtoreg, regwrite, memwrite, instr_done, illegal_op};
        return a;
    endfunction

    task automatic push(input string tag, input logic [3:0] st);
        item_t it;
        it.tag = tag;
        it.st  = st;
        it.o   = model(st, mem_ready, op, reset);
        sb.push_back(it);
    endtask

    task automatic check();
        item_t it;
        outs_t a;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty got 0 entries required 1");
            return;
        end
        it = sb.pop_front();
        a  = observed();
        checks++;
        assert (state === it.st) else begin
            errors++;
            $error("FAIL %s.state got %0d required %0d", it.tag, state, it.st);
        end
        checks++;
        assert (a === it.o) else begin
            errors++;
            $error("FAIL %s.outs got %b required %b", it.tag, a, it.o);
        end
    endtask

    // One clock: drive on the falling edge, compare shortly after.
    task automatic cyc(input string tag, input logic rst, input logic [2:0] o,
                       input logic mr, input logic [3:0] exp_st);
        @(negedge clk);
        reset     = rst;
        op        = o;
        mem_ready = mr;
        push(tag, exp_st);
        #1;
        check();
    endtask

    initial begin
        // Reset state
        cyc("rst", 1'b1, 3'd0, 1'b1, 4'd0);
        cyc("rst2", 1'b1, 3'd0, 1'b1, 4'd0);

        // R-type, op change in EXEC must be ignored
        cyc("r_fetch", 1'b0, 3'd0, 1'b1, 4'd0);
        cyc("r_dec",   1'b0, 3'd0, 1'b1, 4'd1);
        cyc("r_exec",  1'b0, 3'd5, 1'b1, 4'd6);
        cyc("r_aluwb", 1'b0, 3'd5, 1'b1, 4'd7);

        // Load with two stall cycles in MEMRD
        cyc("lw_fetch", 1'b0, 3'd1, 1'b1, 4'd0);
        cyc("lw_dec",   1'b0, 3'd1, 1'b1, 4'd1);
        cyc("lw_adr",   1'b0, 3'd1, 1'b1, 4'd2);
        cyc("lw_rd0",   1'b0, 3'd1, 1'b0, 4'd3);
        cyc("lw_rd1",   1'b0, 3'd1, 1'b0, 4'd3);
        cyc("lw_rd2",   1'b0, 3'd1, 1'b1, 4'd3);
        cyc("lw_wb",    1'b0, 3'd1, 1'b1, 4'd4);

        // Store with one stall in MEMWR
        cyc("sw_fetch", 1'b0, 3'd2, 1'b1, 4'd0);
        cyc("sw_dec",   1'b0, 3'd2, 1'b1, 4'd1);
        cyc("sw_adr",   1'b0, 3'd2, 1'b1, 4'd2);
        cyc("sw_wr0",   1'b0, 3'd2, 1'b0, 4'd5);
        cyc("sw_wr1",   1'b0, 3'd2, 1'b1, 4'd5);

        // Fetch stall, then branch and jump
        cyc("f_stall",  1'b0, 3'd3, 1'b0, 4'd0);
        cyc("f_go",     1'b0, 3'd3, 1'b1, 4'd0);
        cyc("beq_dec",  1'b0, 3'd3, 1'b1, 4'd1);
        cyc("beq_br",   1'b0, 3'd3, 1'b1, 4'd8);
        cyc("j_fetch",  1'b0, 3'd5, 1'b1, 4'd0);
        cyc("j_dec",    1'b0, 3'd5, 1'b1, 4'd1);
        cyc("j_jump",   1'b0, 3'd5, 1'b1, 4'd11);

        // addi
        cyc("ad_fetch", 1'b0, 3'd4, 1'b1, 4'd0);
        cyc("ad_dec",   1'b0, 3'd4, 1'b1, 4'd1);
        cyc("ad_ex",    1'b0, 3'd4, 1'b1, 4'd9);
        cyc("ad_wb",    1'b0, 3'd4, 1'b1, 4'd10);

        // Illegal opcodes
        cyc("il_fetch", 1'b0, 3'd7, 1'b1, 4'd0);
        cyc("il_dec",   1'b0, 3'd7, 1'b1, 4'd1);
        cyc("il_fetch2",1'b0, 3'd6, 1'b1, 4'd0);
        cyc("il_dec6",  1'b0, 3'd6, 1'b1, 4'd1);

        // Asynchronous reset in the middle of a stalled store
        cyc("ar_fetch", 1'b0, 3'd2, 1'b1, 4'd0);
        cyc("ar_dec",   1'b0, 3'd2, 1'b1, 4'd1);
        cyc("ar_adr",   1'b0, 3'd2, 1'b1, 4'd2);
        cyc("ar_wr",    1'b0, 3'd2, 1'b0, 4'd5);
        #1;
        reset = 1'b1;
        push("ar_async", 4'd0);
        #1;
        check();
        cyc("ar_hold",  1'b1, 3'd2, 1'b1, 4'd0);
        cyc("ar_rel",   1'b0, 3'd2, 1'b1, 4'd0);
        cyc("ar_dec2",  1'b0, 3'd0, 1'b1, 4'd1);
        cyc("ar_exec",  1'b0, 3'd0, 1'b1, 4'd6);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain got %0d required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
